// File: rtl/motor_ramp_if.sv
// Command/status bundle between a motor ramp controller and its driver.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready are both high.
interface motor_ramp_if #(
    parameter int SIZE = 12
);
    logic [SIZE-1:0] cmd_width;
    logic            cmd_dir;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            estop;
    logic            period_done;
    logic [SIZE-1:0] width;
    logic            dir;
    logic            at_target;
    logic [1:0]      fsm_state;

    modport master (
        output cmd_width, cmd_dir, cmd_valid, estop, period_done,
        input  cmd_ready, width, dir, at_target, fsm_state
    );

    modport slave (
        input  cmd_width, cmd_dir, cmd_valid, estop, period_done,
        output cmd_ready, width, dir, at_target, fsm_state
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slew-limited PWM duty controller: ramps duty per PWM period, brakes to zero and
// waits a dead time before reversing, and forces zero duty on emergency stop.
module motor_ramp_ctrl #(
    parameter int SIZE         = 12,
    parameter int PERIOD       = 4000,
    parameter int STEP         = 40,
    parameter int DEAD_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    motor_ramp_if.slave bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRAKE = 2'd1,
        DEAD  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CW = (DEAD_PERIODS < 1) ? 1 : $clog2(DEAD_PERIODS + 1);
    localparam logic [SIZE-1:0] PERIOD_V = SIZE'(PERIOD);
    localparam logic [SIZE-1:0] STEP_V   = SIZE'(STEP);
    localparam logic [CW-1:0]   DEAD_V   = CW'(DEAD_PERIODS);

    state_t          state, state_next;
    logic [SIZE-1:0] width, width_next;
    logic            dir, dir_next;
    logic [SIZE-1:0] tgt_width, tgt_width_next;
    logic            tgt_dir, tgt_dir_next;
    logic [CW-1:0]   dead_cnt, dead_cnt_next;
    logic            ready;
    logic            at_tgt;
    logic            accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            width     <= '0;
            dir       <= 1'b0;
            tgt_width <= '0;
            tgt_dir   <= 1'b0;
            dead_cnt  <= '0;
        end else begin
            state     <= state_next;
            width     <= width_next;
            dir       <= dir_next;
            tgt_width <= tgt_width_next;
            tgt_dir   <= tgt_dir_next;
            dead_cnt  <= dead_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        width_next     = width;
        dir_next       = dir;
        tgt_width_next = tgt_width;
        tgt_dir_next   = tgt_dir;
        dead_cnt_next  = dead_cnt;
        accept         = bus.cmd_valid && ready;

        // The new target lands in the register; this cycle's step still uses the old one.
        if (accept) begin
            tgt_width_next = (bus.cmd_width > PERIOD_V) ? PERIOD_V : bus.cmd_width;
            tgt_dir_next   = bus.cmd_dir;
        end

        if (bus.estop) begin
            width_next = '0;
            state_next = STOP;
        end else begin
            case (state)
                RUN: begin
                    if (dir != tgt_dir) begin
                        state_next = BRAKE;
                    end else if (bus.period_done) begin
                        if (width < tgt_width)
                            width_next = ((tgt_width - width) > STEP_V) ? width + STEP_V : tgt_width;
                        else if (width > tgt_width)
                            width_next = ((width - tgt_width) > STEP_V) ? width - STEP_V : tgt_width;
                    end
                end
                BRAKE: begin
                    if (width == '0) begin
                        state_next    = DEAD;
                        dead_cnt_next = '0;
                    end else if (bus.period_done) begin
                        width_next = (width > STEP_V) ? width - STEP_V : '0;
                    end
                end
                DEAD: begin
                    width_next = '0;
                    // A zero dead time leaves immediately; otherwise leave on the last counted pulse.
                    if (dead_cnt >= DEAD_V) begin
                        dir_next   = tgt_dir;
                        state_next = RUN;
                    end else if (bus.period_done) begin
                        if ((dead_cnt + CW'(1)) == DEAD_V) begin
                            dir_next   = tgt_dir;
                            state_next = RUN;
                        end else begin
                            dead_cnt_next = dead_cnt + CW'(1);
                        end
                    end
                end
                STOP: begin
                    width_next    = '0;
                    state_next    = DEAD;
                    dead_cnt_next = '0;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_comb begin
        ready  = (state == RUN) && !bus.estop;
        at_tgt = (state == RUN) && (width == tgt_width) && (dir == tgt_dir);
    end

    assign bus.cmd_ready = ready;
    assign bus.at_target = at_tgt;
    assign bus.width     = width;
    assign bus.dir       = dir;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: vector table plus reset and clamp sequences.
module tb_motor_ramp_ctrl;
    localparam int SIZE = 12;

    typedef struct {
        logic            pd;
        logic            valid;
        logic [SIZE-1:0] cmd_w;
        logic            cmd_d;
        logic            estop;
        logic [SIZE-1:0] exp_w;
        logic            exp_dir;
        logic            exp_ready;
        logic            exp_at;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    motor_ramp_if #(.SIZE(SIZE)) bus ();

    motor_ramp_ctrl #(
        .SIZE(SIZE), .PERIOD(4000), .STEP(40), .DEAD_PERIODS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input int got, input int exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic vec_t mk(input int pd, input int valid, input int cw, input int cd,
                                input int es, input int ew, input int ed, input int er,
                                input int ea);
        vec_t v;
        v.pd        = 1'(pd);
        v.valid     = 1'(valid);
        v.cmd_w     = SIZE'(cw);
        v.cmd_d     = 1'(cd);
        v.estop     = 1'(es);
        v.exp_w     = SIZE'(ew);
        v.exp_dir   = 1'(ed);
        v.exp_ready = 1'(er);
        v.exp_at    = 1'(ea);
        return v;
    endfunction

    task automatic add(input int pd, input int valid, input int cw, input int cd, input int es,
                       input int ew, input int ed, input int er, input int ea);
        vecs.push_back(mk(pd, valid, cw, cd, es, ew, ed, er, ea));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        bus.period_done = v.pd;
        bus.cmd_valid   = v.valid;
        bus.cmd_width   = v.cmd_w;
        bus.cmd_dir     = v.cmd_d;
        bus.estop       = v.estop;
        @(posedge clk);
        #1;
        bus.period_done = 1'b0;
        bus.cmd_valid   = 1'b0;
        chk({tag, " width"}, int'(bus.width), int'(v.exp_w));
        chk({tag, " dir"}, int'(bus.dir), int'(v.exp_dir));
        chk({tag, " cmd_ready"}, int'(bus.cmd_ready), int'(v.exp_ready));
        chk({tag, " at_target"}, int'(bus.at_target), int'(v.exp_at));
    endtask

    task automatic reset_check(input logic es, input string tag);
        @(negedge clk);
        rst       = 1'b1;
        bus.estop = es;
        @(posedge clk);
        #1;
        chk({tag, " state"}, int'(bus.fsm_state), 0);
        chk({tag, " width"}, int'(bus.width), 0);
        chk({tag, " dir"}, int'(bus.dir), 0);
        chk({tag, " at_target"}, int'(bus.at_target), 1);
        chk({tag, " cmd_ready"}, int'(bus.cmd_ready), es ? 0 : 1);
        @(negedge clk);
        rst       = 1'b0;
        bus.estop = 1'b0;
    endtask

    initial begin
        bus.cmd_width   = '0;
        bus.cmd_dir     = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.estop       = 1'b0;
        bus.period_done = 1'b0;
        repeat (2) @(posedge clk);
        reset_check(1'b0, "reset");

        // Ramp up to 200, then a target that is not a multiple of the step.
        add(0, 1, 200, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, 0, 40 * k, 0, 1, (k == 5) ? 1 : 0);
        add(0, 1, 190, 0, 0, 200, 0, 1, 0);
        add(1, 0, 0, 0, 0, 190, 0, 1, 1);
        add(0, 1, 120, 0, 0, 190, 0, 1, 0);
        add(1, 0, 0, 0, 0, 150, 0, 1, 0);
        add(1, 0, 0, 0, 0, 120, 0, 1, 1);
        // Reversal: the transition cycle ignores period_done, then brake, dead time, ramp.
        add(0, 1, 120, 1, 0, 120, 0, 1, 0);
        add(1, 0, 0, 0, 0, 120, 0, 0, 0);
        add(1, 0, 0, 0, 0, 80, 0, 0, 0);
        add(1, 0, 0, 0, 0, 40, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1, 0);
        add(1, 0, 0, 0, 0, 40, 1, 1, 0);
        add(1, 0, 0, 0, 0, 80, 1, 1, 0);
        add(1, 0, 0, 0, 0, 120, 1, 1, 1);
        // Estop at 400 with a competing command and pulse, then resume to stored target.
        add(0, 1, 400, 1, 0, 120, 1, 1, 0);
        for (int k = 4; k <= 10; k++) add(1, 0, 0, 0, 0, 40 * k, 1, 1, (k == 10) ? 1 : 0);
        add(1, 1, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 1, 1, 0);
        for (int k = 1; k <= 10; k++) add(1, 0, 0, 0, 0, 40 * k, 1, 1, (k == 10) ? 1 : 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

        // Clamp: 4095 saturates to 4000, reached on the 100th pulse and held.
        reset_check(1'b0, "clamp reset");
        apply(mk(0, 1, 4095, 0, 0, 0, 0, 1, 0), "clamp cmd");
        for (int p = 1; p <= 103; p++)
            apply(mk(1, 0, 0, 0, 0, (p < 100) ? 40 * p : 4000, 0, 1, (p >= 100) ? 1 : 0),
                  $sformatf("clamp p%0d", p));

        // Reset while in the dead time after a reversal request; rst outranks estop.
        reset_check(1'b0, "rev reset");
        apply(mk(0, 1, 80, 0, 0, 0, 0, 1, 0), "rev cmd0");
        apply(mk(1, 0, 0, 0, 0, 40, 0, 1, 0), "rev p1");
        apply(mk(1, 0, 0, 0, 0, 80, 0, 1, 1), "rev p2");
        apply(mk(0, 1, 80, 1, 0, 80, 0, 1, 0), "rev cmd1");
        apply(mk(0, 0, 0, 0, 0, 80, 0, 0, 0), "rev brake");
        apply(mk(1, 0, 0, 0, 0, 40, 0, 0, 0), "rev b1");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rev b2");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "rev dead");
        chk("rev in dead", int'(bus.fsm_state), 2);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "rev d1");
        reset_check(1'b1, "dead reset");
        apply(mk(0, 1, 40, 0, 0, 0, 0, 1, 0), "post cmd");
        apply(mk(1, 0, 0, 0, 0, 40, 0, 1, 1), "post p1");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
